fsk_status_uart_tx: RTL and testbench

Host-bound UART transmitter for the FSK transmitter top. It serializes 16-bit status/acknowledge words (current FSK state, PLL lock flags) onto the FTDI TX line, sending them to the host as 2-byte frames. This is the reverse direction of the 2-byte host command channel. It uses the same 8N1, 57600-baud format at 48 MHz, and the frame byte order matches the command protocol: high byte first.

---
 rtl/fsk_status_uart_tx.sv | 145 ++++++++++++++
 tb/tb_fsk_status_uart_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fsk_status_uart_tx.sv
// 8N1 UART transmitter for 16-bit status words, high byte first.
// Define FSK_STATUS_CHECKSUM_EN to append an XOR checksum byte.
module fsk_status_uart_tx #(
    parameter int CLK_FREQ   = 48000000,
    parameter int BAUD_RATE  = 57600,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD_RATE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] status_word,
    input  logic        status_valid,
    output logic        status_ready,
    output logic        tx,
    output logic        frame_done
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

`ifdef FSK_STATUS_CHECKSUM_EN
    localparam int BW = 2;
    localparam logic [BW-1:0] LAST_BYTE = 2'd2;
`else
    localparam int BW = 1;
    localparam logic [BW-1:0] LAST_BYTE = 1'b1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [15:0]   word_q, word_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [7:0]    cur_byte;
    logic          cnt_end;

    always_comb begin
`ifdef FSK_STATUS_CHECKSUM_EN
        unique case (byte_q)
            2'd0:    cur_byte = word_q[15:8];
            2'd1:    cur_byte = word_q[7:0];
            default: cur_byte = word_q[15:8] ^ word_q[7:0];
        endcase
`else
        cur_byte = byte_q[0] ? word_q[7:0] : word_q[15:8];
`endif
    end

    assign cnt_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (status_valid) begin
                    word_d  = status_word;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_d];
                    end
                end
            end
            STOP: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        // next byte's start bit follows the stop bit directly
                        byte_d  = byte_q + BW'(1);
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign status_ready = (state_q == IDLE);
    assign tx           = tx_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_fsk_status_uart_tx.sv
// Directed bench for fsk_status_uart_tx at default baud settings.
// Decodes tx mid-bit and checks framing, latency and handshake.
module tb_fsk_status_uart_tx;

    localparam int BC = 833;
`ifdef FSK_STATUS_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int TOTAL = NB * 10 * BC;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] status_word;
    logic        status_valid;
    logic        status_ready;
    logic        tx;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    fsk_status_uart_tx dut (
        .clk          (clk),
        .rst          (rst),
        .status_word  (status_word),
        .status_valid (status_valid),
        .status_ready (status_ready),
        .tx           (tx),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [15:0] w,
                                            input int b);
        if (b == 0) return w[15:8];
        if (b == 1) return w[7:0];
        return w[15:8] ^ w[7:0];
    endfunction

    // Called one cycle after the acceptance edge; returns one cycle
    // after the edge on which frame_done should rise.
    task automatic recv(input logic [15:0] w, input bit busy_pulse,
                        input bit hold, input logic [15:0] nxt);
        logic [29:0] bits;
        int nb;
        bit rdy_seen;
        bit fd_seen;
        bits = '0;
        nb = 0;
        rdy_seen = 0;
        fd_seen = 0;
        for (int c = 0; c < TOTAL; c++) begin
            if (c > 0) step(1);
            if (c == 0) begin
                chk("start_latency", {31'd0, tx}, 32'd0);
                if (hold) status_word = nxt;
                else status_valid = 1'b0;
            end
            if (busy_pulse && c == 5000) begin
                status_valid = 1'b1;
                status_word  = 16'h1234;
            end
            if (busy_pulse && c == 5001) status_valid = 1'b0;
            rdy_seen |= status_ready;
            fd_seen  |= frame_done;
            if (c % BC == BC / 2) begin
                bits[nb] = tx;
                nb++;
            end
        end
        chk("ready_low_in_frame", {31'd0, rdy_seen}, 32'd0);
        chk("no_early_done", {31'd0, fd_seen}, 32'd0);
        for (int b = 0; b < NB; b++)
            chk($sformatf("byte%0d", b), {22'd0, bits[b*10 +: 10]},
                {22'd0, 1'b1, exp_byte(w, b), 1'b0});
        step(1);
        chk("frame_done_time", {31'd0, frame_done}, 32'd1);
        chk("ready_at_done", {31'd0, status_ready}, 32'd1);
    endtask

    initial begin
        bit low_seen;
        bit fd_seen;
        rst = 1'b1;
        status_valid = 1'b1;
        status_word = 16'hAAAA;
        step(1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_ready", {31'd0, status_ready}, 32'd1);
            chk("rst_done", {31'd0, frame_done}, 32'd0);
        end
        rst = 1'b0;
        status_valid = 1'b0;
        low_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            low_seen |= ~tx | frame_done | ~status_ready;
        end
        chk("idle_quiet", {31'd0, low_seen}, 32'd0);

        status_word = 16'hFF00;
        status_valid = 1'b1;
        step(1);
        recv(16'hFF00, 1'b1, 1'b0, 16'h0000);
        step(1);
        chk("done_one_cycle", {31'd0, frame_done}, 32'd0);
        chk("busy_not_queued", {31'd0, status_ready}, 32'd1);
        chk("idle_after", {31'd0, tx}, 32'd1);

        status_word = 16'hA501;
        status_valid = 1'b1;
        step(1);
        recv(16'hA501, 1'b0, 1'b0, 16'h0000);
        step(1);

        status_word = 16'hFF01;
        status_valid = 1'b1;
        step(1);
        recv(16'hFF01, 1'b0, 1'b1, 16'h0000);
        step(1);
        chk("b2b_start", {31'd0, tx}, 32'd0);
        chk("b2b_busy", {31'd0, status_ready}, 32'd0);
        status_valid = 1'b0;
        step(14 * BC + BC / 2);
        chk("lo_bit3", {31'd0, tx}, 32'd0);
        chk("lo_bit3_busy", {31'd0, status_ready}, 32'd0);

        rst = 1'b1;
        status_valid = 1'b1;
        status_word = 16'hFFFF;
        step(1);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_ready", {31'd0, status_ready}, 32'd1);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        status_valid = 1'b0;
        step(1);
        chk("rst_wins", {31'd0, status_ready}, 32'd1);
        fd_seen = 0;
        low_seen = 0;
        for (int i = 0; i < 900; i++) begin
            step(1);
            fd_seen  |= frame_done;
            low_seen |= ~tx;
        end
        chk("no_resume_done", {31'd0, fd_seen}, 32'd0);
        chk("no_resume_tx", {31'd0, low_seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
